// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shift/rotate unit, STEP bits per cycle, valid/ready on both sides.
//   clk       in   rising-edge clock
//   reset_n   in   synchronous active-low reset
//   in_valid  in   request valid
//   in_ready  out  high in IDLE, request can be accepted
//   in_data   in   operand (WIDTH)
//   in_shamt  in   shift amount (SHAMT_W), 0..WIDTH-1
//   in_mode   in   00 LSL, 01 LSR, 10 ASR, 11 ROR
//   out_valid out  high in DONE, result valid
//   out_ready in   consumer accepts result
//   out_data  out  shifted result (WIDTH)
//   out_carry out  last bit shifted out (ROR: result MSB)
module seq_shift_unit #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
    state_e state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d, res, asr, lsl_out, rsh_out;
    logic [1:0] mode_q, mode_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic carry_q, carry_d;
    int k;
    always_comb begin
        k = (int'(rem_q) < STEP) ? int'(rem_q) : STEP;
        // Bits that leave the word this cycle: LSL loses data[WIDTH-k]; right shifts and ROR
        // (whose new MSB is the old data[k-1]) all report data[k-1].
        lsl_out = data_q >> (WIDTH - k);
        rsh_out = data_q >> (k - 1);
        // Kept separate so the arithmetic shift is not turned logical by an unsigned ternary.
        asr = $signed(data_q) >>> k;
        res = mode_q == 2'b00 ? data_q << k :
              mode_q == 2'b01 ? data_q >> k :
              mode_q == 2'b10 ? asr :
              (data_q >> k) | (data_q << (WIDTH - k));
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        carry_d = carry_q;
        if (state_q == IDLE && in_valid) begin
            data_d  = in_data;
            mode_d  = in_mode;
            rem_d   = in_shamt;
            carry_d = 1'b0;
            state_d = in_shamt != '0 ? SHIFT : DONE;
        end else if (state_q == SHIFT) begin
            data_d  = res;
            carry_d = mode_q == 2'b00 ? lsl_out[0] : rsh_out[0];
            rem_d   = rem_q - SHAMT_W'(k);
            state_d = rem_d == '0 ? DONE : SHIFT;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            mode_q  <= '0;
            rem_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            carry_q <= carry_d;
        end
    end
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out_data  = data_q;
    assign out_carry = carry_q;
endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: scoreboard bench for seq_shift_unit with STEP = 1, 3 and 4 instances.
module tb_seq_shift_unit;
    typedef struct packed {logic [15:0] d; logic c;} res_t;
    logic clk = 1'b0;
    logic reset_n;
    logic iv[3], ir[3], ov[3], orr[3], oc[3];
    logic [15:0] id[3], od[3];
    logic [3:0] is[3];
    logic [1:0] im[3];
    res_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    seq_shift_unit #(.WIDTH(16), .STEP(1)) u_s1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .in_shamt(is[0]), .in_mode(im[0]), .out_valid(ov[0]), .out_ready(orr[0]),
        .out_data(od[0]), .out_carry(oc[0]));
    seq_shift_unit #(.WIDTH(16), .STEP(3)) u_s3 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .in_shamt(is[1]), .in_mode(im[1]), .out_valid(ov[1]), .out_ready(orr[1]),
        .out_data(od[1]), .out_carry(oc[1]));
    seq_shift_unit #(.WIDTH(16), .STEP(4)) u_s4 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .in_shamt(is[2]), .in_mode(im[2]), .out_valid(ov[2]), .out_ready(orr[2]),
        .out_data(od[2]), .out_carry(oc[2]));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic res_t golden(input logic [1:0] m, input logic [15:0] d, input logic [3:0] s);
        int n = int'(s);
        res_t r;
        r.d = d;
        r.c = 1'b0;
        if (n != 0) begin
            case (m)
                2'd0: begin r.d = d << n; r.c = d[16-n]; end
                2'd1: begin r.d = d >> n; r.c = d[n-1]; end
                2'd2: begin r.d = $signed(d) >>> n; r.c = d[n-1]; end
                default: begin r.d = (d >> n) | (d << (16 - n)); r.c = r.d[15]; end
            endcase
        end
        return r;
    endfunction
    // Inputs change #1 after a rising edge and outputs are sampled there too.
    // in_valid stays high with junk operands while busy to show it is ignored.
    task automatic run_op(input int u, input logic [1:0] m, input logic [15:0] d, input logic [3:0] s,
                          input res_t e, input int lat, input int hold);
        int n;
        res_t exp_r;
        check("in_ready_before", 32'(ir[u]), 32'd1);
        sb.push_back(e);
        iv[u] = 1'b1;
        id[u] = d;
        is[u] = s;
        im[u] = m;
        @(posedge clk); #1;
        id[u] = 16'($urandom);
        is[u] = 4'($urandom);
        im[u] = 2'($urandom);
        n = 1;
        while (!ov[u] && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, lat);
        repeat (hold) begin
            check("hold_data", 32'(od[u]), 32'(sb[0].d));
            check("hold_carry", 32'(oc[u]), 32'(sb[0].c));
            check("hold_valid", 32'(ov[u]), 32'd1);
            check("hold_busy", 32'(ir[u]), 32'd0);
            @(posedge clk); #1;
        end
        exp_r = sb.pop_front();
        check("out_valid", 32'(ov[u]), 32'd1);
        check("out_data", 32'(od[u]), 32'(exp_r.d));
        check("out_carry", 32'(oc[u]), 32'(exp_r.c));
        orr[u] = 1'b1;
        @(posedge clk); #1;
        orr[u] = 1'b0;
        iv[u] = 1'b0;
        check("idle_valid", 32'(ov[u]), 32'd0);
        check("idle_ready", 32'(ir[u]), 32'd1);
    endtask
    initial begin
        int steps[3] = '{1, 3, 4};
        int seen;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            orr[i] = 1'b0;
            id[i] = '0;
            is[i] = '0;
            im[i] = '0;
        end
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst_ready", 32'(ir[i]), 32'd1);
            check("rst_valid", 32'(ov[i]), 32'd0);
            check("rst_data", 32'(od[i]), 32'd0);
            check("rst_carry", 32'(oc[i]), 32'd0);
        end
        run_op(0, 2'd0, 16'h8001, 4'd1, res_t'{16'h0002, 1'b1}, 2, 0);
        run_op(0, 2'd2, 16'h8000, 4'd3, res_t'{16'hF000, 1'b0}, 4, 0);
        run_op(0, 2'd1, 16'h00F0, 4'd5, res_t'{16'h0007, 1'b1}, 6, 0);
        run_op(0, 2'd3, 16'h0001, 4'd4, res_t'{16'h1000, 1'b0}, 5, 5);
        run_op(0, 2'd0, 16'hBEEF, 4'd0, res_t'{16'hBEEF, 1'b0}, 1, 0);
        run_op(2, 2'd1, 16'hFFFF, 4'd15, res_t'{16'h0001, 1'b1}, 5, 0);
        iv[0] = 1'b1;
        id[0] = 16'hA5A5;
        is[0] = 4'd9;
        im[0] = 2'd0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("midrst_ready", 32'(ir[0]), 32'd1);
        check("midrst_valid", 32'(ov[0]), 32'd0);
        check("midrst_data", 32'(od[0]), 32'd0);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ov[0]) seen++;
        end
        check("midrst_no_result", seen, 0);
        for (int u = 0; u < 3; u++) begin
            for (int t = 0; t < 25; t++) begin
                logic [1:0] m;
                logic [15:0] d;
                logic [3:0] s;
                int lat;
                m = 2'($urandom_range(0, 3));
                d = 16'($urandom);
                s = 4'($urandom_range(0, 15));
                lat = s == 0 ? 1 : (int'(s) + steps[u] - 1) / steps[u] + 1;
                run_op(u, m, d, s, golden(m, d, s), lat, $urandom_range(0, 2));
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
